// File: rtl/mux_nx1_rr_if.sv
// Handshake bundle for mux_nx1_rr: N producer channels in, one registered consumer port out.
// The slave modport is the mux; the master modport is the producers/consumer side.
interface mux_nx1_rr_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  mode,
        input  sel,
        output out_data,
        output out_chan,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output mode,
        output sel,
        input  out_data,
        input  out_chan,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mux_nx1_rr.sv
// N:1 valid/ready multiplexer with fixed or round-robin channel selection feeding
// a single registered output stage (one-cycle latency, full throughput).
module mux_nx1_rr #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mux_nx1_rr_if.slave    bus
);
    localparam int SW = $clog2(N);
    localparam logic [SW:0]   N_EXT   = (SW+1)'(N);
    localparam logic [SW-1:0] PTR_RST = SW'(N - 1);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_chan;
    logic          r_out_valid;
    logic [SW-1:0] r_ptr;

    logic          w_load;
    logic          w_gvalid;
    logic [SW-1:0] w_gidx;
    logic [SW:0]   w_idx;
    logic [N-1:0]  w_in_ready;

    assign w_load = !r_out_valid || bus.out_ready;

    // Grant selection: direct index in fixed mode, rotating search after r_ptr in round-robin mode.
    always_comb begin
        w_gvalid = 1'b0;
        w_gidx   = '0;
        w_idx    = '0;
        if (bus.mode == 1'b0) begin
            if (int'(bus.sel) < N) begin
                w_gvalid = bus.in_valid[bus.sel];
                w_gidx   = bus.sel;
            end else begin
                w_gvalid = 1'b0;
                w_gidx   = '0;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                w_idx = {1'b0, r_ptr} + (SW+1)'(k);
                if (w_idx >= N_EXT) begin
                    w_idx = w_idx - N_EXT;
                end else begin
                    w_idx = w_idx;
                end
                if (!w_gvalid && bus.in_valid[w_idx[SW-1:0]]) begin
                    w_gvalid = 1'b1;
                    w_gidx   = w_idx[SW-1:0];
                end else begin
                    w_gvalid = w_gvalid;
                    w_gidx   = w_gidx;
                end
            end
        end
    end

    // Ready is the one-hot grant, gated by output-stage space and reset.
    always_comb begin
        w_in_ready = '0;
        if (w_gvalid && w_load && !rst) begin
            w_in_ready = N'(1) << w_gidx;
        end else begin
            w_in_ready = '0;
        end
    end

    // Output stage and round-robin pointer; r_ptr only advances on round-robin transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= PTR_RST;
        end else if (w_load) begin
            if (w_gvalid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.in_data[w_gidx*W +: W];
                r_out_chan  <= w_gidx;
                if (bus.mode == 1'b1) begin
                    r_ptr <= w_gidx;
                end else begin
                    r_ptr <= r_ptr;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed self-checking bench for mux_nx1_rr with N=4, W=8.
module tb_mux_nx1_rr;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mux_nx1_rr_if #(.N(4), .W(8)) bus ();

    mux_nx1_rr #(.N(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, "_data"},  32'(bus.out_data),  32'(d));
        check({tag, "_chan"},  32'(bus.out_chan),  32'(c));
    endtask

    int rr_seq_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int rr_seq_b [4] = '{1, 3, 1, 3};
    logic [7:0] ch_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.in_valid  = 4'b1111;
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.out_ready = 1'b1;

        // Reset held two cycles with every channel valid.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_in_ready", 32'(bus.in_ready), 32'(4'b0000));
            check_out("rst_out", 1'b0, 8'h00, 2'd0);
        end
        rst = 1'b0;
        settle();
        check("rr_first_grant", 32'(bus.in_ready), 32'(4'b0001));

        // Fixed mode, sel=2 then sel=3.
        bus.mode = 1'b0;
        bus.sel  = 2'd2;
        settle();
        check("fix_ready_sel2", 32'(bus.in_ready), 32'(4'b0100));
        tick();
        check_out("fix_sel2", 1'b1, 8'h33, 2'd2);
        bus.sel = 2'd3;
        settle();
        check("fix_ready_sel3", 32'(bus.in_ready), 32'(4'b1000));
        tick();
        check_out("fix_sel3", 1'b1, 8'h44, 2'd3);

        // Fixed mode, selected channel idle.
        bus.sel      = 2'd1;
        bus.in_valid = 4'b1101;
        settle();
        check("idle_ready", 32'(bus.in_ready), 32'(4'b0000));
        tick();
        check_out("idle_out", 1'b0, 8'h44, 2'd3);

        // Round-robin rotation, all valid.
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("rr_all_ready", 32'(bus.in_ready), 32'(4'b0001 << rr_seq_a[i]));
            tick();
            check_out("rr_all", 1'b1, ch_data[rr_seq_a[i]], 2'(rr_seq_a[i]));
        end

        // Round-robin over channels 1 and 3 only.
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_sparse_chan", 32'(bus.out_chan), 32'(rr_seq_b[i]));
        end

        // Backpressure with channel 2 parked in the output register.
        bus.in_valid = 4'b0100;
        tick();
        check_out("bp_load", 1'b1, 8'h33, 2'd2);
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_ready", 32'(bus.in_ready), 32'(4'b0000));
            tick();
            check_out("bp_hold", 1'b1, 8'h33, 2'd2);
        end
        bus.out_ready = 1'b1;
        settle();
        check("bp_release_ready", 32'(bus.in_ready), 32'(4'b1000));
        tick();
        check_out("bp_release", 1'b1, 8'h44, 2'd3);

        // Mode switch keeps the round-robin pointer.
        bus.in_valid = 4'b0010;
        tick();
        check_out("ms_rr_ch1", 1'b1, 8'h22, 2'd1);
        bus.mode     = 1'b0;
        bus.sel      = 2'd0;
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_out("ms_fix_ch0", 1'b1, 8'h11, 2'd0);
        end
        bus.mode = 1'b1;
        settle();
        check("ms_rr_ready", 32'(bus.in_ready), 32'(4'b0100));
        tick();
        check_out("ms_rr_ch2", 1'b1, 8'h33, 2'd2);

        // Reset while the output holds pending data.
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        settle();
        check("mr_ready", 32'(bus.in_ready), 32'(4'b0000));
        tick();
        check_out("mr_out", 1'b0, 8'h00, 2'd0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        settle();
        check("mr_first_ready", 32'(bus.in_ready), 32'(4'b0001));
        tick();
        check_out("mr_first", 1'b1, 8'h11, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
- Parametrised successor of the 2:1 select mux.
- Selects one of N W-bit input channels and drives it to one registered output stage with valid/ready handshakes.
- Two select modes: fixed (external channel index) and round-robin (fair rotation among valid channels).
- Sits between multiple producers and a single consumer (shared bus / shared datapath port).

Parameters:
- N, 4, number of input channels; legal range 2..16.
- W, 8, data width per channel; legal range ≥1.
- SW, $clog2(N), width of channel index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SW  channel index used when mode=0.
- out_data  output  W  registered selected data.
- out_chan  output  SW  registered index of the channel that produced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=N-1, so the first RR search starts at channel 0.
  - in_ready is all-zero while rst=1.
- load = !out_valid || out_ready. The output register accepts new data only when load=1.
- Grant, combinational, at most one-hot:
  - mode=0: grant[sel]=in_valid[sel]. If sel≥N (non-power-of-2 N), no grant.
  - mode=1: first i with in_valid[i]=1, searching ptr+1, ptr+2, … with wrap modulo N. Ptr itself is checked last. No valid channel means no grant.
- in_ready[i] = grant[i] & load & !rst. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer, at the next edge:
  - out_data ← channel i data.
  - out_chan ← i.
  - out_valid ← 1.
  - In mode=1, ptr ← i.
- On load=1 with no grant: out_valid ← 0. out_data and out_chan hold their previous values.
- On out_valid=1 & out_ready=0: all outputs hold, in_ready all 0.
- Latency: input transfer to out_valid is 1 cycle. Sustained throughput is 1 transfer/cycle when out_ready=1.
- ptr updates only on transfers made in mode=1. It is retained across mode switches.
- sel and mode are sampled combinationally each cycle. Changing them never alters data already in the output register.
- Round-robin fairness: with all N valid continuously and out_ready=1, the grant order is 0,1,…,N-1,0,… Each channel is granted exactly once per N transfers.
- Reset mid-operation: the pending output is discarded (out_valid=0 next cycle) and no input transfer occurs in the reset cycle.
- Inputs are not registered. Producers must hold in_data and in_valid until in_ready is seen (standard valid/ready rule; valid must not depend on ready).

Test Plan:
- Reset: assert rst 2 cycles with all in_valid=1 → in_ready=0000, out_valid=0, out_data=0x00 and out_chan=0 throughout. First RR grant after release is ch0.
- Fixed mode: N=4, W=8, mode=0, sel=2, in_data={0x44,0x33,0x22,0x11}, in_valid=1111, out_ready=1 → in_ready=0100. Next cycle out_data=0x33, out_chan=2, out_valid=1. Then sel=3 → next cycle out_data=0x44, out_chan=3.
- Fixed-mode idle: mode=0, sel=1, in_valid=1101 → in_ready=0000 and out_valid falls to 0 one cycle later, out_data holds.
- Round-robin rotation: mode=1, in_valid=1111, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3. Then in_valid=1010 → sequence 1,3,1,3.
- Backpressure: out_valid=1 (out_chan=2), out_ready=0 for 3 cycles → out_data/out_chan stable, in_ready=0000, ptr unchanged. Raising out_ready → next transfer is ch3 (RR continues after 2).
- Mode switch and reset: in RR, transfer ch1, switch to mode=0 sel=0 for 2 transfers, back to mode=1 → next grant ch2 (ptr retained). Asserting rst while out_valid=1 → out_valid=0 next cycle, ptr reset so next grant is ch0.
